// File: rtl/module_input_deco_gray_filt.sv
// Input decoder for Gray or binary board codes: two-flop synchroniser, refresh-rate
// sampling, STABLE_SAMPLES debounce, conversion to binary, change and error pulses.
module module_input_deco_gray_filt #(
   parameter int WIDTH          = 4,
   parameter int INPUT_REFRESH  = 2700000,
   parameter int STABLE_SAMPLES = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] codigo_gray_i,
   input  logic             modo_i,
   output logic [WIDTH-1:0] codigo_bin_o,
   output logic             cambio_o,
   output logic             error_o
);

   localparam int RW = $clog2(INPUT_REFRESH);
   localparam int CW = $clog2(STABLE_SAMPLES + 1);
   localparam logic [RW-1:0] REF_LOAD = RW'(INPUT_REFRESH - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_SAMPLES);

   logic [WIDTH-1:0] sync1_r;
   logic [WIDTH-1:0] sync_r;
   logic [RW-1:0]    ref_cnt_r;
   logic             tick;
   logic [WIDTH-1:0] cand_r, cand_next;
   logic [CW-1:0]    cnt_r, cnt_next;
   logic [WIDTH-1:0] acc_r, acc_next;
   logic             accept;
   logic             bad_step;
   logic [WIDTH-1:0] bin_next;

   assign tick = (ref_cnt_r == '0);

   // Acceptance and conversion both look at the value acc_r takes on this edge,
   // so the output word and cambio_o move together.
   always_comb begin
      cand_next = cand_r;
      cnt_next  = cnt_r;
      accept    = 1'b0;
      if (tick) begin
         if (sync_r == cand_r) begin
            if (cnt_r != CNT_MAX) cnt_next = cnt_r + CW'(1);
         end else begin
            cand_next = sync_r;
            cnt_next  = CW'(1);
         end
         accept = (cnt_next == CNT_MAX) && (sync_r != acc_r);
      end
      acc_next = accept ? sync_r : acc_r;
      bad_step = ($countones(sync_r ^ acc_r) != 1);

      bin_next = acc_next;
      if (!modo_i) begin
         for (int unsigned i = 1; i < WIDTH; i++) begin
            bin_next[WIDTH-1-i] = bin_next[WIDTH-i] ^ acc_next[WIDTH-1-i];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_r      <= '0;
         sync_r       <= '0;
         ref_cnt_r    <= REF_LOAD;
         cand_r       <= '0;
         cnt_r        <= '0;
         acc_r        <= '0;
         codigo_bin_o <= '0;
         cambio_o     <= 1'b0;
         error_o      <= 1'b0;
      end else begin
         sync1_r      <= codigo_gray_i;
         sync_r       <= sync1_r;
         ref_cnt_r    <= tick ? REF_LOAD : ref_cnt_r - RW'(1);
         cand_r       <= cand_next;
         cnt_r        <= cnt_next;
         acc_r        <= acc_next;
         codigo_bin_o <= bin_next;
         cambio_o     <= accept;
         error_o      <= accept && !modo_i && bad_step;
      end
   end

endmodule

// File: tb/tb_module_input_deco_gray_filt.sv
// Directed bench for module_input_deco_gray_filt: a 4-bit/3-sample instance and an
// 8-bit/1-sample instance, both refreshing every 4 cycles.
module tb_module_input_deco_gray_filt;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] code4;
   logic       modo4;
   logic [3:0] bin4;
   logic       chg4, err4;
   logic [7:0] code8;
   logic       modo8;
   logic [7:0] bin8;
   logic       chg8, err8;

   int n_checks = 0;
   int n_fail   = 0;
   int n, pre;

   always #5 clk = ~clk;

   module_input_deco_gray_filt #(.WIDTH(4), .INPUT_REFRESH(4), .STABLE_SAMPLES(3)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .codigo_gray_i(code4), .modo_i(modo4),
      .codigo_bin_o(bin4), .cambio_o(chg4), .error_o(err4)
   );

   module_input_deco_gray_filt #(.WIDTH(8), .INPUT_REFRESH(4), .STABLE_SAMPLES(1)) u_dut8 (
      .clk_i(clk), .rst_i(rst), .codigo_gray_i(code8), .modo_i(modo8),
      .codigo_bin_o(bin8), .cambio_o(chg8), .error_o(err8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Waits for cambio on the selected instance; n = negedges elapsed (maxc+1 on timeout),
   // pre = cycles before the pulse where the output word moved or error was set.
   task automatic wait_chg(input int sel, input int maxc, output int n, output int pre);
      logic [7:0] start;
      start = sel ? bin8 : {4'b0, bin4};
      n = 0;
      pre = 0;
      while (n < maxc) begin
         @(negedge clk);
         n++;
         if (sel ? chg8 : chg4) return;
         if ((sel ? bin8 : {4'b0, bin4}) != start || (sel ? err8 : err4)) pre++;
      end
      n = maxc + 1;
   endtask

   // Counts cycles with any pulse or output-word movement on the 4-bit instance.
   task automatic watch4(input int cycles, output int events);
      logic [3:0] start;
      start = bin4;
      events = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (chg4 || err4 || bin4 != start) events++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst = 1'b1; code4 = 4'b0110; modo4 = 1'b0; code8 = 8'h00; modo8 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_bin4", bin4, 4'h0);
      check("rst_chg4", chg4, 1'b0);
      check("rst_err4", err4, 1'b0);
      check("rst_bin8", bin8, 8'h00);

      // 1: 0110 accepted from 0000 exactly 12 edges after release, distance 2
      rst = 1'b0;
      wait_chg(0, 30, n, pre);
      check("t1_lat", n, 12);
      check("t1_pre", pre, 0);
      check("t1_bin", bin4, 4'b0100);
      check("t1_err", err4, 1'b1);
      @(negedge clk);
      check("t1_chg_off", chg4, 1'b0);
      check("t1_err_off", err4, 1'b0);
      check("t1_bin_hold", bin4, 4'b0100);

      // 2: 0111 is a legal single-bit step
      code4 = 4'b0111;
      wait_chg(0, 30, n, pre);
      check("t2_pre", pre, 0);
      check("t2_bin", bin4, 4'b0101);
      check("t2_chg", chg4, 1'b1);
      check("t2_err", err4, 1'b0);
      watch4(80, n);
      check("t2_hold_quiet", n, 0);

      // 3: glitches lasting one and two ticks are discarded
      code4 = 4'b0101;
      repeat (4) @(negedge clk);
      code4 = 4'b0111;
      watch4(40, n);
      check("t3_glitch1", n, 0);
      code4 = 4'b0101;
      repeat (8) @(negedge clk);
      code4 = 4'b0111;
      watch4(40, n);
      check("t3_glitch2", n, 0);
      check("t3_bin", bin4, 4'b0101);

      // 4: binary pass-through, then back to Gray reconverts without a pulse
      modo4 = 1'b1;
      @(negedge clk);
      check("t4_reconv_bin", bin4, 4'b0111);
      check("t4_reconv_chg", chg4, 1'b0);
      code4 = 4'b1010;
      wait_chg(0, 30, n, pre);
      check("t4_pre", pre, 0);
      check("t4_bin", bin4, 4'b1010);
      check("t4_err", err4, 1'b0);
      modo4 = 1'b0;
      @(negedge clk);
      check("t4_gray_bin", bin4, 4'b1100);
      check("t4_gray_chg", chg4, 1'b0);
      check("t4_gray_err", err4, 1'b0);

      // 5: single-sample acceptance, 8-bit
      code8 = 8'h80;
      wait_chg(1, 12, n, pre);
      check("t5a_bin", bin8, 8'hFF);
      check("t5a_err", err8, 1'b0);
      @(negedge clk);
      check("t5a_chg_off", chg8, 1'b0);
      code8 = 8'h81;
      wait_chg(1, 12, n, pre);
      check("t5b_bin", bin8, 8'hFE);
      check("t5b_err", err8, 1'b0);

      // 6a: reset part-way through a debounce
      code4 = 4'b0110;
      watch4(10, n);
      check("t6a_before", n, 0);
      rst = 1'b1;
      @(negedge clk);
      check("t6a_rst_bin", bin4, 4'h0);
      check("t6a_rst_chg", chg4, 1'b0);
      rst = 1'b0;
      wait_chg(0, 30, n, pre);
      check("t6a_lat", n, 12);
      check("t6a_bin", bin4, 4'b0100);
      check("t6a_err", err4, 1'b1);

      // 6b: reset landing on the acceptance edge
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      watch4(11, n);
      check("t6b_quiet", n, 0);
      rst = 1'b1;
      @(negedge clk);
      check("t6b_rst_chg", chg4, 1'b0);
      check("t6b_rst_err", err4, 1'b0);
      check("t6b_rst_bin", bin4, 4'h0);
      rst = 1'b0;
      wait_chg(0, 30, n, pre);
      check("t6b_lat", n, 12);
      check("t6b_bin", bin4, 4'b0100);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/module_input_deco_gray_filt.md
Name: module_input_deco_gray_filt

Overview:
- Parametrised successor of the team's Gray-input decoder.
- Synchronises a WIDTH-bit external code (switches/encoder), samples it at a programmable refresh rate and debounces it over STABLE_SAMPLES consecutive samples.
- Converts the accepted value to binary, either Gray→binary or binary pass-through.
- Flags each accepted change and any illegal Gray transition. Sits between board inputs and the counter/display logic.

Parameters:
- WIDTH, 4, code width in bits (≥2).
- INPUT_REFRESH, 2700000, clock cycles between samples (≥2).
- STABLE_SAMPLES, 3, consecutive identical samples required before a value is accepted (≥1).

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- codigo_gray_i  in  WIDTH  raw asynchronous input code.
- modo_i  in  1  0 = Gray input, 1 = binary pass-through; synchronous, sampled every cycle.
- codigo_bin_o  out  WIDTH  registered binary result.
- cambio_o  out  1  one-cycle pulse, new value on codigo_bin_o.
- error_o  out  1  one-cycle pulse, accepted Gray transition had Hamming distance ≠1 (Gray mode only).

Behaviour:
- Reset (rst_i=1 at clk edge): sync stages, candidate, stable count, accepted register, codigo_bin_o, cambio_o and error_o all 0. Refresh counter loads INPUT_REFRESH-1. Reset dominates every other event, including mid-debounce and mid-acceptance.

Synchroniser:
- Two flops on codigo_gray_i, giving sync_r.
- No logic between the stages.

Refresh tick:
- Down-counter, $clog2(INPUT_REFRESH) bits, reloads INPUT_REFRESH-1 after reaching 0.
- tick = (counter==0), combinational.
- First tick is the INPUT_REFRESH-th edge after reset release; ticks then repeat every INPUT_REFRESH cycles.

Debounce (evaluated only on tick edges):
- If sync_r == cand_r: cnt ← min(cnt+1, STABLE_SAMPLES).
- Else: cand_r ← sync_r, cnt ← 1.
- Let n be the new cnt value. If n == STABLE_SAMPLES and sync_r ≠ acc_r, then acc_r ← sync_r (acceptance edge).
- cnt saturates at STABLE_SAMPLES, so a held value is never re-accepted.
- STABLE_SAMPLES=1: accept on the first differing tick.
- A value that disappears before reaching STABLE_SAMPLES is discarded. acc_r is unchanged.

Acceptance side effects (registered on the acceptance edge, visible the following cycle):
- cambio_o pulses 1 for exactly one cycle.
- error_o pulses 1 for exactly one cycle when modo_i=0 and popcount(sync_r ^ acc_r) ≠ 1.
- error_o is never asserted when modo_i=1.
- The value is still accepted when error_o fires.

Conversion (every cycle):
- codigo_bin_o ← f(acc_next, modo_i), where acc_next is the value acc_r takes on this edge.
- f Gray: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i = WIDTH-2..0.
- f binary: b = g.
- codigo_bin_o therefore changes in the same cycle cambio_o is high.
- A modo_i change reconverts acc_r after 1 cycle without pulsing cambio_o.

Latency:
- Input edge to sync_r: 2 cycles.
- Accepted after STABLE_SAMPLES ticks in which sync_r holds the new value.
- Output 1 cycle after the acceptance tick edge.

Test Plan:
1. WIDTH=4, INPUT_REFRESH=4, STABLE_SAMPLES=3, modo_i=0; after reset hold codigo_gray_i=0110 -> codigo_bin_o=0100 one cycle after 3rd qualifying tick; cambio_o=1 and error_o=1 (0000→0110 distance 2) for exactly one cycle; all outputs 0 before.
2. Continue from 1, apply 0111 -> codigo_bin_o=0101, cambio_o pulse, error_o stays 0; hold 20 more ticks -> no further cambio_o.
3. Glitch: from accepted 0111, drive 0101 for 1 tick then back to 0111 -> codigo_bin_o stays 0101 (binary of 0111), no cambio_o/error_o; drive 0101 for exactly 2 ticks -> still no change.
4. modo_i=1, input 1010 held -> codigo_bin_o=1010 after 3 ticks, error_o never 1; toggle modo_i to 0 -> codigo_bin_o=1100 next cycle, no cambio_o.
5. WIDTH=8, STABLE_SAMPLES=1, modo_i=0: input 0x80 -> codigo_bin_o=0xFF on first tick, cambio_o=1, error_o=0; input 0x81 -> 0xFE.
6. Reset mid-debounce (after 2 of 3 qualifying ticks) and on an acceptance edge -> all outputs 0 next cycle; refresh counter restarts, full INPUT_REFRESH×STABLE_SAMPLES period required before acceptance.
